instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//  Upstream stage of the execution unit: fetches 19-bit instruction words from a sync-read
//  instruction memory, splits each into opcode/addr1/addr2/addr3, presents them to the EU
//  with a valid/ready handshake. One instruction in flight; PC advances only on accepted issue.
//  Stops on a HALT word or at end of program; restarts on a start pulse.
// PARAMETERS
//  PC_W      8    program counter / imem address width
//  PROG_LEN  256  instruction count; PC = PROG_LEN-1 is the last slot (2 <= PROG_LEN <= 2**PC_W)
//  HALT_WORD 19'h7FFFF  encoding that stops fetch; never issued to the EU
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous, active-high reset
//  start        in   1     1-cycle pulse: begin execution at PC=0 (honoured in IDLE/HALT only)
//  imem_rd      out  1     instruction memory read strobe
//  imem_addr    out  PC_W  instruction memory address (= pc)
//  imem_data    in   19    read data, valid the cycle after imem_rd; [18:15] op, [14:10] a1, [9:5] a2, [4:0] a3
//  opcode       out  4     EU opcode
//  addr1        out  5     EU operand-A register address
//  addr2        out  5     EU operand-B register address
//  addr3        out  5     EU result register address
//  issue_valid  out  1     opcode/addr1..3 valid for the EU
//  issue_ready  in   1     EU accepts; transfer when issue_valid & issue_ready at a rising edge
//  halted       out  1     1 in HALT state
//  pc           out  PC_W  current program counter
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; pc=0; imem_rd=0; issue_valid=0; halted=0;
//   opcode=addr1=addr2=addr3=0; instruction register=0. Takes effect mid-handshake; an
//   in-flight instruction is dropped.
//  FSM states: IDLE, FETCH, DECODE, ISSUE, HALT. Outputs registered (Moore).
//   IDLE  : start -> pc<=0, FETCH. Otherwise stay.
//   FETCH : imem_rd=1, imem_addr=pc; -> DECODE next cycle.
//   DECODE: capture imem_data. If ==HALT_WORD -> HALT (no issue). Else load
//           opcode/addr1..3 from fields, -> ISSUE.
//   ISSUE : issue_valid=1; fields held stable while issue_ready=0 (no timeout).
//           On transfer: if pc==PROG_LEN-1 -> HALT (pc unchanged); else pc<=pc+1, FETCH.
//   HALT  : halted=1, issue_valid=0. start -> halted=0, pc<=0, FETCH.
//  start in FETCH/DECODE/ISSUE is ignored. start coincident with reset release: reset wins.
//  Latency: start sampled at edge 0 -> FETCH cycle 1, DECODE cycle 2, issue_valid from cycle 3.
//   Throughput with issue_ready held 1: one instruction per 3 cycles.
//  issue_valid deasserts the cycle after transfer; never asserted outside ISSUE.
//  PC never wraps: end-of-program terminates in HALT before pc+1 exceeds PROG_LEN-1.
//  imem_rd is high only in FETCH; imem_addr always equals pc.
// CONFIGURATION
//  INSTR_COUNT_EN defined: extra output retired_cnt [15:0]; +1 on every issue transfer,
//   cleared by reset and by an honoured start; saturates at 16'hFFFF.
//  INSTR_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately, state IDLE; start ignored while rst=1.
//  2 Program {4'h1,1,2,3},{4'h2,4,5,6},HALT_WORD, issue_ready=1, start @edge0 -> issue_valid
//    at cycles 3 and 6 with op=1/a=1,2,3 then op=2/a=4,5,6; halted=1 at cycle 9; pc=2.
//  3 Backpressure: issue_ready=0 for 4 cycles in ISSUE -> fields/issue_valid stable, pc and
//    imem_rd unchanged; transfer on 5th cycle, pc+1 next cycle.
//  4 PROG_LEN=4, no HALT word -> exactly 4 transfers, halted=1, pc=3, no imem_rd for address 4.
//  5 start pulsed during ISSUE -> ignored; start in HALT -> pc=0, refetch from address 0.
//  6 INSTR_COUNT_EN: case 2 -> retired_cnt=2; restart clears to 0; rst in ISSUE -> cnt=0, no transfer.

Source files
------------

// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bus: instruction-memory read port plus the EU issue handshake.
// master = fetch/decode unit, slave = memory + execution unit side.
interface instr_fetch_decode_if #(
  parameter int PC_W = 8
);
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [18:0]     imem_data;
  logic [3:0]      opcode;
  logic [4:0]      addr1;
  logic [4:0]      addr2;
  logic [4:0]      addr3;
  logic            issue_valid;
  logic            issue_ready;

  modport master (
    output imem_rd, imem_addr, opcode, addr1, addr2, addr3, issue_valid,
    input  imem_data, issue_ready
  );

  modport slave (
    input  imem_rd, imem_addr, opcode, addr1, addr2, addr3, issue_valid,
    output imem_data, issue_ready
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode: one instruction in flight, Moore FSM IDLE/FETCH/DECODE/ISSUE/HALT.
// Optional INSTR_COUNT_EN adds a saturating retired-instruction counter (retired_cnt).
module instr_fetch_decode #(
  parameter int          PC_W      = 8,
  parameter int          PROG_LEN  = 256,
  parameter logic [18:0] HALT_WORD = 19'h7FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  instr_fetch_decode_if.master   bus,
  output logic                   halted,
`ifdef INSTR_COUNT_EN
  output logic [15:0]            retired_cnt,
`endif
  output logic [PC_W-1:0]        pc
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [18:0]     ir;
  logic            ir_load;
  logic            xfer;
  logic            start_ok;
  logic            imem_rd_q;
  logic            issue_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_load  = 1'b0;
    xfer     = 1'b0;
    start_ok = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          pc_n     = '0;
          state_n  = S_FETCH;
        end
      end
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        // HALT_WORD never reaches the EU; the previous fields stay in ir
        if (bus.imem_data == HALT_WORD) begin
          state_n = S_HALT;
        end else begin
          ir_load = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.issue_ready) begin
          xfer = 1'b1;
          if (pc == LAST_PC) begin
            state_n = S_HALT;
          end else begin
            pc_n    = pc + 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          start_ok = 1'b1;
          pc_n     = '0;
          state_n  = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs registered from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= '0;
      ir            <= '0;
      imem_rd_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      halted        <= 1'b0;
    end else begin
      pc            <= pc_n;
      imem_rd_q     <= (state_n == S_FETCH);
      issue_valid_q <= (state_n == S_ISSUE);
      halted        <= (state_n == S_HALT);
      if (ir_load) ir <= bus.imem_data;
    end
  end

  assign bus.imem_rd     = imem_rd_q;
  assign bus.imem_addr   = pc;
  assign bus.issue_valid = issue_valid_q;
  assign bus.opcode      = ir[18:15];
  assign bus.addr1       = ir[14:10];
  assign bus.addr2       = ir[9:5];
  assign bus.addr3       = ir[4:0];

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              retired_cnt <= '0;
    else if (start_ok)                    retired_cnt <= '0;
    else if (xfer && retired_cnt != '1)   retired_cnt <= retired_cnt + 16'd1;
  end
`else
  logic unused_ok;
  assign unused_ok = start_ok ^ xfer;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench: main instance (3-word program ending in HALT) and a PROG_LEN=4 instance.
module tb_instr_fetch_decode;
  localparam logic [18:0] HW = 19'h7FFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start4 = 1'b0;
  logic       halted, halted4;
  logic [7:0] pc, pc4;
`ifdef INSTR_COUNT_EN
  logic [15:0] cnt, cnt4;
`endif

  int n_vec = 0;
  int n_err = 0;
  int xfer4 = 0;
  int bad4  = 0;

  logic [18:0] mem  [0:255];
  logic [18:0] mem4 [0:255];

  always #5 clk = ~clk;

  instr_fetch_decode_if #(.PC_W(8)) bus  ();
  instr_fetch_decode_if #(.PC_W(8)) bus4 ();

  instr_fetch_decode #(.PC_W(8), .PROG_LEN(256), .HALT_WORD(HW)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .halted(halted),
`ifdef INSTR_COUNT_EN
    .retired_cnt(cnt),
`endif
    .pc(pc)
  );

  instr_fetch_decode #(.PC_W(8), .PROG_LEN(4), .HALT_WORD(HW)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bus(bus4), .halted(halted4),
`ifdef INSTR_COUNT_EN
    .retired_cnt(cnt4),
`endif
    .pc(pc4)
  );

  // sync-read instruction memories
  always @(posedge clk) if (bus.imem_rd)  bus.imem_data  <= mem[bus.imem_addr];
  always @(posedge clk) if (bus4.imem_rd) bus4.imem_data <= mem4[bus4.imem_addr];

  always @(posedge clk) begin
    if (bus4.issue_valid && bus4.issue_ready) xfer4 <= xfer4 + 1;
    if (bus4.imem_rd && bus4.imem_addr > 8'd3) bad4 <= bad4 + 1;
  end

  function automatic logic [18:0] fw(input logic [3:0] op, input logic [4:0] a1,
                                     input logic [4:0] a2, input logic [4:0] a3);
    return {op, a1, a2, a3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = HW;
      mem4[i] = fw(4'hF, 5'd31, 5'd31, 5'd31);
    end
    mem[0] = fw(4'h1, 5'd1, 5'd2, 5'd3);
    mem[1] = fw(4'h2, 5'd4, 5'd5, 5'd6);
    for (int i = 0; i < 4; i++) mem4[i] = fw(4'(i + 3), 5'(i), 5'(i + 1), 5'(i + 2));
    bus.issue_ready  = 1'b1;
    bus4.issue_ready = 1'b1;

    // reset state, start while in reset ignored
    repeat (2) tick;
    chk("rst_valid", bus.issue_valid, 0);
    chk("rst_rd", bus.imem_rd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_op", bus.opcode, 0);
    start = 1'b1;
    tick;
    chk("rst_start_rd", bus.imem_rd, 0);
    rst = 1'b0;
    start = 1'b0;
    tick;
    chk("idle_rd", bus.imem_rd, 0);

    // two instructions then HALT word
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("c1_rd", bus.imem_rd, 1);
    chk("c1_addr", bus.imem_addr, 0);
    chk("c1_valid", bus.issue_valid, 0);
    tick;
    chk("c2_valid", bus.issue_valid, 0);
    chk("c2_rd", bus.imem_rd, 0);
    tick;
    chk("c3_valid", bus.issue_valid, 1);
    chk("c3_op", bus.opcode, 1);
    chk("c3_a1", bus.addr1, 1);
    chk("c3_a2", bus.addr2, 2);
    chk("c3_a3", bus.addr3, 3);
    tick;
    chk("c4_valid", bus.issue_valid, 0);
    chk("c4_pc", pc, 1);
    chk("c4_rd", bus.imem_rd, 1);
    chk("c4_addr", bus.imem_addr, 1);
    repeat (2) tick;
    chk("c6_valid", bus.issue_valid, 1);
    chk("c6_op", bus.opcode, 2);
    chk("c6_a1", bus.addr1, 4);
    chk("c6_a2", bus.addr2, 5);
    chk("c6_a3", bus.addr3, 6);
    tick;
    chk("c7_pc", pc, 2);
    repeat (2) tick;
    chk("c9_halted", halted, 1);
    chk("c9_pc", pc, 2);
    chk("c9_valid", bus.issue_valid, 0);
`ifdef INSTR_COUNT_EN
    chk("c9_cnt", cnt, 2);
`endif
    tick;
    chk("halt_rd", bus.imem_rd, 0);
    chk("halt_hold", halted, 1);

    // restart from HALT with backpressure; start during ISSUE ignored
    bus.issue_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("rs_halted", halted, 0);
    chk("rs_pc", pc, 0);
    chk("rs_rd", bus.imem_rd, 1);
    chk("rs_addr", bus.imem_addr, 0);
`ifdef INSTR_COUNT_EN
    chk("rs_cnt", cnt, 0);
`endif
    repeat (2) tick;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", bus.issue_valid, 1);
      chk("bp_op", bus.opcode, 1);
      chk("bp_a3", bus.addr3, 3);
      chk("bp_pc", pc, 0);
      chk("bp_rd", bus.imem_rd, 0);
      start = (k == 1);
      tick;
    end
    start = 1'b0;
    bus.issue_ready = 1'b1;
    chk("bp5_valid", bus.issue_valid, 1);
    tick;
    chk("bp_post_valid", bus.issue_valid, 0);
    chk("bp_post_pc", pc, 1);
    chk("bp_post_rd", bus.imem_rd, 1);
    for (int i = 0; i < 20 && !halted; i++) tick;
    chk("bp_halted", halted, 1);
    chk("bp_halt_pc", pc, 2);
`ifdef INSTR_COUNT_EN
    chk("bp_cnt", cnt, 2);
`endif

    // mid-cycle reset from HALT
    #2 rst = 1'b1;
    #1;
    chk("mrst_halted", halted, 0);
    chk("mrst_pc", pc, 0);
    tick;
    rst = 1'b0;
    tick;

    // reset during ISSUE drops the instruction
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    chk("ri_valid_pre", bus.issue_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ri_valid", bus.issue_valid, 0);
    chk("ri_op", bus.opcode, 0);
    chk("ri_a1", bus.addr1, 0);
    chk("ri_rd", bus.imem_rd, 0);
    tick;
    start = 1'b1;
    tick;
    rst = 1'b0;
    start = 1'b0;
    tick;
    chk("ri_idle_rd", bus.imem_rd, 0);
    chk("ri_idle_valid", bus.issue_valid, 0);
`ifdef INSTR_COUNT_EN
    chk("ri_cnt", cnt, 0);
`endif

    // PROG_LEN=4 instance: end of program without HALT word
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    for (int i = 0; i < 40 && !halted4; i++) tick;
    tick;
    chk("p4_halted", halted4, 1);
    chk("p4_pc", pc4, 3);
    chk("p4_xfers", xfer4, 4);
    chk("p4_noaddr4", bad4, 0);
    chk("p4_last_op", bus4.opcode, 6);
    chk("p4_valid", bus4.issue_valid, 0);
`ifdef INSTR_COUNT_EN
    chk("p4_cnt", cnt4, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
